// File: rtl/tx_dispatcher_if.sv
// Host-stream and peripheral TX FIFO bundle for tx_dispatcher.
// slave: the dispatcher's view. master: the host/FIFO side driving it.
interface tx_dispatcher_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] host_data;
  logic                  host_valid;
  logic                  host_ready;
  logic [7:0]            periph_enable;
  logic [7:0]            tx_fifo_full;
  logic [7:0]            tx_fifo_almost_full;
  logic [7:0]            tx_fifo_wr_en;
  logic [DATA_WIDTH-1:0] tx_fifo_din;
  logic                  busy;
  logic [2:0]            dest;
  logic                  pkt_done;
  logic [15:0]           drop_count;

  modport slave (
    input  host_data, host_valid, periph_enable, tx_fifo_full, tx_fifo_almost_full,
    output host_ready, tx_fifo_wr_en, tx_fifo_din, busy, dest, pkt_done, drop_count
  );

  modport master (
    output host_data, host_valid, periph_enable, tx_fifo_full, tx_fifo_almost_full,
    input  host_ready, tx_fifo_wr_en, tx_fifo_din, busy, dest, pkt_done, drop_count
  );
endinterface

// File: rtl/tx_dispatcher.sv
// Host-to-peripheral packet router: parses header + N payload words from the
// FT601 receive stream and writes payload into one of eight TX FIFOs through
// a registered write port, or discards it when the destination is disabled.
module tx_dispatcher #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input logic              clk,
  input logic              rst,
  tx_dispatcher_if.slave   bus
);

  typedef enum logic [1:0] {
    S_HEADER  = 2'd0,
    S_PAYLOAD = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [2:0]            dest_q;
  logic [7:0]            wr_en_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  pkt_done_q;
  logic [15:0]           drop_q;

  logic                  ready_c;
  logic                  busy_c;
  logic                  accept;
  logic                  wr_pending;
  logic                  last_word;
  logic [2:0]            hdr_id;
  logic [LEN_WIDTH-1:0]  hdr_len;

  assign hdr_id     = bus.host_data[DATA_WIDTH-1 -: 3];
  assign hdr_len    = bus.host_data[LEN_WIDTH-1:0];
  assign accept     = bus.host_valid & ready_c;
  // A write issued last cycle is not yet reflected in the full flag, so the
  // almost-full flag guards the slot that write is about to consume.
  assign wr_pending = wr_en_q[dest_q];
  assign last_word  = (remaining_q == LEN_WIDTH'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_HEADER;
    else     state_q <= state_d;
  end

  // Next-state logic: headers open a packet, the word with remaining==1 closes it
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HEADER: begin
        if (accept && (hdr_len != '0))
          state_d = bus.periph_enable[hdr_id] ? S_PAYLOAD : S_DISCARD;
      end
      S_PAYLOAD, S_DISCARD: begin
        if (accept && last_word) state_d = S_HEADER;
      end
      default: state_d = S_HEADER;
    endcase
  end

  // Output logic: ready follows only the current destination's FIFO flags
  always_comb begin
    ready_c = 1'b0;
    busy_c  = 1'b0;
    case (state_q)
      S_HEADER:  ready_c = 1'b1;
      S_PAYLOAD: begin
        busy_c  = 1'b1;
        ready_c = wr_pending ? ~bus.tx_fifo_almost_full[dest_q]
                             : ~bus.tx_fifo_full[dest_q];
      end
      S_DISCARD: begin
        busy_c  = 1'b1;
        ready_c = 1'b1;
      end
      default: ready_c = 1'b0;
    endcase
    if (rst) ready_c = 1'b0;
  end

  // Packet bookkeeping, registered FIFO write port and drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q <= '0;
      dest_q      <= '0;
      wr_en_q     <= '0;
      din_q       <= '0;
      pkt_done_q  <= 1'b0;
      drop_q      <= '0;
    end else begin
      wr_en_q    <= '0;
      pkt_done_q <= 1'b0;
      if (accept) begin
        case (state_q)
          S_HEADER: begin
            dest_q      <= hdr_id;
            remaining_q <= hdr_len;
            if (hdr_len == '0) pkt_done_q <= 1'b1;
          end
          S_PAYLOAD: begin
            wr_en_q     <= 8'(1) << dest_q;
            din_q       <= bus.host_data;
            remaining_q <= remaining_q - LEN_WIDTH'(1);
            if (last_word) pkt_done_q <= 1'b1;
          end
          S_DISCARD: begin
            if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            remaining_q <= remaining_q - LEN_WIDTH'(1);
            if (last_word) pkt_done_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.host_ready    = ready_c;
  assign bus.busy          = busy_c;
  assign bus.dest          = dest_q;
  assign bus.tx_fifo_wr_en = wr_en_q;
  assign bus.tx_fifo_din   = din_q;
  assign bus.pkt_done      = pkt_done_q;
  assign bus.drop_count    = drop_q;

endmodule
